issueq_int: RTL and testbench
=============================

// Module: issueq_int
// PURPOSE
//  Integer issue queue: the requesting side of the ready_int/issue_int handshake.
//  - Holds dispatched integer ops until both source operands are valid.
//  - Captures missing operands by snooping CDB tag/data.
//  - Presents the oldest ready op to the issue unit on ready_int.
//  - Removes that op when issue_int grants it in the same cycle.
// PARAMETERS
//  DEPTH   4   queue entries (>=2); collapsing, entry 0 = oldest
//  TAG_W   6   physical/ROB tag width
//  DATA_W 32   operand / CDB data width
//  OP_W    4   opcode width
// PORTS
//  clk               in   1       clock, all state on rising edge
//  reset             in   1       synchronous, active-low; state cleared when reset==0
//  flush             in   1       drop every entry (branch mispredict)
//  dispatch_en       in   1       write new op this cycle
//  dispatch_opcode   in   OP_W    opcode
//  dispatch_rstag    in   TAG_W   rs producer tag
//  dispatch_rsvalid  in   1       rs data already valid
//  dispatch_rsdata   in   DATA_W  rs data (used when rsvalid)
//  dispatch_rttag    in   TAG_W   rt producer tag
//  dispatch_rtvalid  in   1       rt data already valid
//  dispatch_rtdata   in   DATA_W  rt data (used when rtvalid)
//  dispatch_rdtag    in   TAG_W   destination tag
//  dispatch_full     out  1       no free entry; dispatch_en ignored while high
//  cdb_valid         in   1       CDB broadcast valid
//  cdb_tagout        in   TAG_W   CDB tag
//  cdb_out           in   DATA_W  CDB data
//  ready_int         out  1       a selected op is ready to issue
//  issue_int         in   1       grant; only meaningful while ready_int is high
//  opcode            out  OP_W    selected op
//  rsdata            out  DATA_W  selected op rs
//  rtdata            out  DATA_W  selected op rt
//  rdtag             out  TAG_W   selected op destination tag
// BEHAVIOUR
//  Reset and outputs
//  - Reset: all valid bits 0; dispatch_full=0, ready_int=0.
//  - opcode/rsdata/rtdata/rdtag are 0 when ready_int=0.
//  Entry state
//  - Per entry: valid, opcode, rdtag, {tag, valid, data} per source.
//  Selection (combinational)
//  - Select the lowest-index entry with valid & rsvalid & rtvalid.
//  - ready_int = a selected entry exists; outputs come from that entry, so zero added latency.
//  - Only operand state registered before this edge counts; a CDB hit this cycle gives readiness next cycle.
//  Issue
//  - ready_int & issue_int at an edge removes the selected entry.
//  - Younger entries shift down one index, preserving age order.
//  - issue_int while ready_int=0 is ignored.
//  Dispatch
//  - dispatch_en & ~dispatch_full writes the first free index after any issue compaction.
//  - Simultaneous issue + dispatch with queue full: dispatch_full is high, so the dispatch is dropped.
//  - dispatch_full = all DEPTH entries valid (registered count == DEPTH).
//  CDB snoop
//  - Every valid entry with src valid=0 and tag==cdb_tagout while cdb_valid captures cdb_out and sets src valid.
//  - rs and rt may match the same tag; both capture.
//  - Snoop applies to entries that shift in the same cycle; data follows the entry.
//  Flush
//  - flush clears all valid bits at the edge.
//  - flush beats dispatch, issue and snoop; the grant is still consumed by the issue unit.
//  Reset mid-operation
//  - Contents are discarded; no ready_int in the cycle after reset.
// CONFIGURATION
//  - ISSUEQ_DISPATCH_BYPASS_EN defined: a dispatching op whose src is invalid and whose tag matches the same-cycle CDB broadcast is written with that src valid, holding cdb_out.
//  - ISSUEQ_DISPATCH_BYPASS_EN undefined: no bypass. The dispatch stage must forward same-cycle CDB data itself; otherwise the entry waits forever.
// TESTING
//  - Reset then dispatch rs/rt valid (5, 7, rdtag 3):
//    next cycle ready_int=1, rsdata=5, rtdata=7, rdtag=3; issue_int=1 -> queue empty next cycle.
//  - Dispatch A (rs tag 9 pending), then B (all valid):
//    B issues first; CDB tag 9 data 0xAA -> A ready next cycle with rsdata=0xAA.
//  - Fill 4 entries -> dispatch_full=1; extra dispatch is dropped.
//    Issue one -> dispatch_full=0 next cycle; order of the remaining 3 is preserved.
//  - Hold ready_int=1 with issue_int=0 for 3 cycles:
//    outputs stable, entry retained; grant on cycle 4 removes it.
//  - Dispatch rs tag 12 invalid, same cycle CDB tag 12 data 0x55:
//    with macro, ready next cycle, rsdata=0x55; without macro, ready_int stays 0.
//  - 3 valid entries, flush with simultaneous issue_int and dispatch_en:
//    next cycle empty, ready_int=0, dispatch_full=0.

Source files
------------

// File: rtl/issueq_int.sv
// rtl/issueq_int.sv - collapsing integer issue queue with CDB snoop and oldest-ready select
// Optional feature: ISSUEQ_DISPATCH_BYPASS_EN (same-cycle CDB capture on dispatch)
module issueq_int #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              dispatch_en,
    input  logic [OP_W-1:0]   dispatch_opcode,
    input  logic [TAG_W-1:0]  dispatch_rstag,
    input  logic              dispatch_rsvalid,
    input  logic [DATA_W-1:0] dispatch_rsdata,
    input  logic [TAG_W-1:0]  dispatch_rttag,
    input  logic              dispatch_rtvalid,
    input  logic [DATA_W-1:0] dispatch_rtdata,
    input  logic [TAG_W-1:0]  dispatch_rdtag,
    output logic              dispatch_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tagout,
    input  logic [DATA_W-1:0] cdb_out,
    output logic              ready_int,
    input  logic              issue_int,
    output logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] rsdata,
    output logic [DATA_W-1:0] rtdata,
    output logic [TAG_W-1:0]  rdtag
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [OP_W-1:0]   op_q     [DEPTH];
    logic [OP_W-1:0]   op_d     [DEPTH];
    logic [TAG_W-1:0]  rd_q     [DEPTH];
    logic [TAG_W-1:0]  rd_d     [DEPTH];
    logic [TAG_W-1:0]  rs_tag_q [DEPTH];
    logic [TAG_W-1:0]  rs_tag_d [DEPTH];
    logic              rs_v_q   [DEPTH];
    logic              rs_v_d   [DEPTH];
    logic [DATA_W-1:0] rs_d_q   [DEPTH];
    logic [DATA_W-1:0] rs_d_d   [DEPTH];
    logic [TAG_W-1:0]  rt_tag_q [DEPTH];
    logic [TAG_W-1:0]  rt_tag_d [DEPTH];
    logic              rt_v_q   [DEPTH];
    logic              rt_v_d   [DEPTH];
    logic [DATA_W-1:0] rt_d_q   [DEPTH];
    logic [DATA_W-1:0] rt_d_d   [DEPTH];

    // Post-snoop view of every entry; slot DEPTH is an always-empty filler for the shift.
    logic              sn_valid  [DEPTH+1];
    logic [OP_W-1:0]   sn_op     [DEPTH+1];
    logic [TAG_W-1:0]  sn_rd     [DEPTH+1];
    logic [TAG_W-1:0]  sn_rs_tag [DEPTH+1];
    logic              sn_rs_v   [DEPTH+1];
    logic [DATA_W-1:0] sn_rs_d   [DEPTH+1];
    logic [TAG_W-1:0]  sn_rt_tag [DEPTH+1];
    logic              sn_rt_v   [DEPTH+1];
    logic [DATA_W-1:0] sn_rt_d   [DEPTH+1];

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              do_issue;
    logic              do_dispatch;
    logic [CNT_W-1:0]  count_after;
    logic              new_rs_v;
    logic [DATA_W-1:0] new_rs_d;
    logic              new_rt_v;
    logic [DATA_W-1:0] new_rt_d;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && rs_v_q[i] && rt_v_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign ready_int     = sel_found;
    assign dispatch_full = (count_q == CNT_W'(DEPTH));
    assign do_issue      = sel_found && issue_int;
    assign do_dispatch   = dispatch_en && !dispatch_full;
    assign count_after   = count_q - CNT_W'(do_issue);

    always_comb begin
        opcode = '0;
        rsdata = '0;
        rtdata = '0;
        rdtag  = '0;
        if (sel_found) begin
            opcode = op_q[sel_idx];
            rsdata = rs_d_q[sel_idx];
            rtdata = rt_d_q[sel_idx];
            rdtag  = rd_q[sel_idx];
        end
    end

    always_comb begin
        new_rs_v = dispatch_rsvalid;
        new_rs_d = dispatch_rsdata;
        new_rt_v = dispatch_rtvalid;
        new_rt_d = dispatch_rtdata;
`ifdef ISSUEQ_DISPATCH_BYPASS_EN
        if (!dispatch_rsvalid && cdb_valid && dispatch_rstag == cdb_tagout) begin
            new_rs_v = 1'b1;
            new_rs_d = cdb_out;
        end
        if (!dispatch_rtvalid && cdb_valid && dispatch_rttag == cdb_tagout) begin
            new_rt_v = 1'b1;
            new_rt_d = cdb_out;
        end
`endif
    end

    always_comb begin
        for (int i = 0; i <= DEPTH; i++) begin
            sn_valid[i]  = 1'b0;
            sn_op[i]     = '0;
            sn_rd[i]     = '0;
            sn_rs_tag[i] = '0;
            sn_rs_v[i]   = 1'b0;
            sn_rs_d[i]   = '0;
            sn_rt_tag[i] = '0;
            sn_rt_v[i]   = 1'b0;
            sn_rt_d[i]   = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            sn_valid[i]  = valid_q[i];
            sn_op[i]     = op_q[i];
            sn_rd[i]     = rd_q[i];
            sn_rs_tag[i] = rs_tag_q[i];
            sn_rs_v[i]   = rs_v_q[i];
            sn_rs_d[i]   = rs_d_q[i];
            sn_rt_tag[i] = rt_tag_q[i];
            sn_rt_v[i]   = rt_v_q[i];
            sn_rt_d[i]   = rt_d_q[i];
            if (cdb_valid && valid_q[i] && !rs_v_q[i] && rs_tag_q[i] == cdb_tagout) begin
                sn_rs_v[i] = 1'b1;
                sn_rs_d[i] = cdb_out;
            end
            if (cdb_valid && valid_q[i] && !rt_v_q[i] && rt_tag_q[i] == cdb_tagout) begin
                sn_rt_v[i] = 1'b1;
                sn_rt_d[i] = cdb_out;
            end
        end
    end

    always_comb begin
        count_d = count_after;
        for (int i = 0; i < DEPTH; i++) begin
            // Entries at or above the issued slot collapse down by one.
            if (do_issue && i >= int'(sel_idx)) begin
                valid_d[i]  = sn_valid[i+1];
                op_d[i]     = sn_op[i+1];
                rd_d[i]     = sn_rd[i+1];
                rs_tag_d[i] = sn_rs_tag[i+1];
                rs_v_d[i]   = sn_rs_v[i+1];
                rs_d_d[i]   = sn_rs_d[i+1];
                rt_tag_d[i] = sn_rt_tag[i+1];
                rt_v_d[i]   = sn_rt_v[i+1];
                rt_d_d[i]   = sn_rt_d[i+1];
            end else begin
                valid_d[i]  = sn_valid[i];
                op_d[i]     = sn_op[i];
                rd_d[i]     = sn_rd[i];
                rs_tag_d[i] = sn_rs_tag[i];
                rs_v_d[i]   = sn_rs_v[i];
                rs_d_d[i]   = sn_rs_d[i];
                rt_tag_d[i] = sn_rt_tag[i];
                rt_v_d[i]   = sn_rt_v[i];
                rt_d_d[i]   = sn_rt_d[i];
            end
            if (do_dispatch && CNT_W'(i) == count_after) begin
                valid_d[i]  = 1'b1;
                op_d[i]     = dispatch_opcode;
                rd_d[i]     = dispatch_rdtag;
                rs_tag_d[i] = dispatch_rstag;
                rs_v_d[i]   = new_rs_v;
                rs_d_d[i]   = new_rs_d;
                rt_tag_d[i] = dispatch_rttag;
                rt_v_d[i]   = new_rt_v;
                rt_d_d[i]   = new_rt_d;
            end
        end
        if (do_dispatch) begin
            count_d = count_after + CNT_W'(1);
        end
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]     <= '0;
                rd_q[i]     <= '0;
                rs_tag_q[i] <= '0;
                rs_v_q[i]   <= 1'b0;
                rs_d_q[i]   <= '0;
                rt_tag_q[i] <= '0;
                rt_v_q[i]   <= 1'b0;
                rt_d_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]     <= op_d[i];
                rd_q[i]     <= rd_d[i];
                rs_tag_q[i] <= rs_tag_d[i];
                rs_v_q[i]   <= rs_v_d[i];
                rs_d_q[i]   <= rs_d_d[i];
                rt_tag_q[i] <= rt_tag_d[i];
                rt_v_q[i]   <= rt_v_d[i];
                rt_d_q[i]   <= rt_d_d[i];
            end
        end
    end

endmodule

// File: tb/tb_issueq_int.sv
// tb/tb_issueq_int.sv - directed and randomized bench for issueq_int against a queue model
module tb_issueq_int;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        dispatch_en;
    logic [3:0]  dispatch_opcode;
    logic [5:0]  dispatch_rstag;
    logic        dispatch_rsvalid;
    logic [31:0] dispatch_rsdata;
    logic [5:0]  dispatch_rttag;
    logic        dispatch_rtvalid;
    logic [31:0] dispatch_rtdata;
    logic [5:0]  dispatch_rdtag;
    logic        dispatch_full;
    logic        cdb_valid;
    logic [5:0]  cdb_tagout;
    logic [31:0] cdb_out;
    logic        ready_int;
    logic        issue_int;
    logic [3:0]  opcode;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic [5:0]  rdtag;

    issueq_int #(.DEPTH(DEPTH), .TAG_W(6), .DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
        .dispatch_rstag(dispatch_rstag), .dispatch_rsvalid(dispatch_rsvalid),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rttag(dispatch_rttag),
        .dispatch_rtvalid(dispatch_rtvalid), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rdtag(dispatch_rdtag), .dispatch_full(dispatch_full),
        .cdb_valid(cdb_valid), .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
        .ready_int(ready_int), .issue_int(issue_int), .opcode(opcode),
        .rsdata(rsdata), .rtdata(rtdata), .rdtag(rdtag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [5:0]  rs_tag;
        bit          rs_v;
        logic [31:0] rs_d;
        logic [5:0]  rt_tag;
        bit          rt_v;
        logic [31:0] rt_d;
    } ent_t;

    ent_t model_q[$];
    bit   known = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_sel();
        for (int i = 0; i < model_q.size(); i++)
            if (model_q[i].rs_v && model_q[i].rt_v) return i;
        return -1;
    endfunction

    // Compare DUT outputs against the model state (outputs depend only on registered state).
    task automatic compare();
        int s;
        if (!known) return;
        s = model_sel();
        chk("ready_int", {31'd0, ready_int}, {31'd0, s >= 0});
        chk("dispatch_full", {31'd0, dispatch_full}, {31'd0, model_q.size() == DEPTH});
        chk("opcode", {28'd0, opcode}, (s >= 0) ? {28'd0, model_q[s].op} : 32'd0);
        chk("rsdata", rsdata, (s >= 0) ? model_q[s].rs_d : 32'd0);
        chk("rtdata", rtdata, (s >= 0) ? model_q[s].rt_d : 32'd0);
        chk("rdtag", {26'd0, rdtag}, (s >= 0) ? {26'd0, model_q[s].rd} : 32'd0);
    endtask

    task automatic model_update();
        int   s;
        bit   was_full;
        ent_t e;
        if (!reset) begin
            model_q.delete();
            known = 1;
            return;
        end
        if (flush) begin
            model_q.delete();
            return;
        end
        s = model_sel();
        was_full = (model_q.size() == DEPTH);
        for (int i = 0; i < model_q.size(); i++) begin
            if (cdb_valid && !model_q[i].rs_v && model_q[i].rs_tag == cdb_tagout) begin
                model_q[i].rs_v = 1;
                model_q[i].rs_d = cdb_out;
            end
            if (cdb_valid && !model_q[i].rt_v && model_q[i].rt_tag == cdb_tagout) begin
                model_q[i].rt_v = 1;
                model_q[i].rt_d = cdb_out;
            end
        end
        if (issue_int && s >= 0) model_q.delete(s);
        if (dispatch_en && !was_full) begin
            e.op = dispatch_opcode; e.rd = dispatch_rdtag;
            e.rs_tag = dispatch_rstag; e.rs_v = dispatch_rsvalid; e.rs_d = dispatch_rsdata;
            e.rt_tag = dispatch_rttag; e.rt_v = dispatch_rtvalid; e.rt_d = dispatch_rtdata;
`ifdef ISSUEQ_DISPATCH_BYPASS_EN
            if (!e.rs_v && cdb_valid && e.rs_tag == cdb_tagout) begin e.rs_v = 1; e.rs_d = cdb_out; end
            if (!e.rt_v && cdb_valid && e.rt_tag == cdb_tagout) begin e.rt_v = 1; e.rt_d = cdb_out; end
`endif
            model_q.push_back(e);
        end
    endtask

    // Entered and left at a negedge with inputs already driven.
    task automatic cycle();
        compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; dispatch_en = 0; issue_int = 0; cdb_valid = 0;
        dispatch_opcode = 0; dispatch_rstag = 0; dispatch_rsvalid = 0; dispatch_rsdata = 0;
        dispatch_rttag = 0; dispatch_rtvalid = 0; dispatch_rtdata = 0; dispatch_rdtag = 0;
        cdb_tagout = 0; cdb_out = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [5:0] rst, input bit rsv, input logic [31:0] rsd,
                        input logic [5:0] rtt, input bit rtv, input logic [31:0] rtd, input logic [5:0] rd);
        dispatch_en = 1; dispatch_opcode = op;
        dispatch_rstag = rst; dispatch_rsvalid = rsv; dispatch_rsdata = rsd;
        dispatch_rttag = rtt; dispatch_rtvalid = rtv; dispatch_rtdata = rtd;
        dispatch_rdtag = rd;
    endtask

    initial begin
        reset = 0;
        idle();
        @(negedge clk);
        cycle();
        cycle();
        reset = 1;
        chk("reset_ready", {31'd0, ready_int}, 32'd0);
        chk("reset_full", {31'd0, dispatch_full}, 32'd0);

        // Single ready op issues with zero added latency.
        disp(4'd1, 6'd0, 1, 32'd5, 6'd0, 1, 32'd7, 6'd3);
        cycle();
        idle();
        chk("t1_ready", {31'd0, ready_int}, 32'd1);
        chk("t1_rs", rsdata, 32'd5);
        chk("t1_rt", rtdata, 32'd7);
        chk("t1_rd", {26'd0, rdtag}, 32'd3);
        issue_int = 1;
        cycle();
        idle();
        chk("t1_empty", {31'd0, ready_int}, 32'd0);
        chk("t1_model_empty", model_q.size(), 32'd0);

        // Younger ready op bypasses a waiting older one; CDB wakes the older one.
        disp(4'd2, 6'd9, 0, 32'd0, 6'd1, 1, 32'd1, 6'd10);
        cycle();
        disp(4'd3, 6'd2, 1, 32'd2, 6'd3, 1, 32'd3, 6'd11);
        cycle();
        idle();
        chk("t2_b_first", {26'd0, rdtag}, 32'd11);
        issue_int = 1;
        cycle();
        idle();
        chk("t2_a_waits", {31'd0, ready_int}, 32'd0);
        cdb_valid = 1; cdb_tagout = 6'd9; cdb_out = 32'hAA;
        chk("t2_no_same_cycle", {31'd0, ready_int}, 32'd0);
        cycle();
        idle();
        chk("t2_a_ready", {31'd0, ready_int}, 32'd1);
        chk("t2_a_rs", rsdata, 32'hAA);
        chk("t2_a_rd", {26'd0, rdtag}, 32'd10);
        issue_int = 1;
        cycle();
        idle();

        // Fill, drop overflow, hold without grant, then drain in order.
        for (int i = 0; i < 4; i++) begin
            disp(4'(i), 6'd0, 1, 32'(100 + i), 6'd0, 1, 32'(200 + i), 6'(20 + i));
            cycle();
        end
        idle();
        chk("t3_full", {31'd0, dispatch_full}, 32'd1);
        disp(4'd9, 6'd0, 1, 32'd1, 6'd0, 1, 32'd1, 6'd24);
        issue_int = 1;
        cycle();
        idle();
        chk("t3_drop_full", {31'd0, dispatch_full}, 32'd0);
        chk("t3_model_3", model_q.size(), 32'd3);
        chk("t3_next", {26'd0, rdtag}, 32'd21);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_hold_rd", {26'd0, rdtag}, 32'd21);
            chk("t4_hold_rs", rsdata, 32'd101);
        end
        issue_int = 1;
        cycle();
        chk("t4_after", {26'd0, rdtag}, 32'd22);
        cycle();
        chk("t3_last", {26'd0, rdtag}, 32'd23);
        cycle();
        idle();
        chk("t3_drained", {31'd0, ready_int}, 32'd0);

        // Same-cycle CDB at dispatch.
        disp(4'd5, 6'd12, 0, 32'd0, 6'd0, 1, 32'd4, 6'd30);
        cdb_valid = 1; cdb_tagout = 6'd12; cdb_out = 32'h55;
        cycle();
        idle();
`ifdef ISSUEQ_DISPATCH_BYPASS_EN
        chk("t5_bypass_ready", {31'd0, ready_int}, 32'd1);
        chk("t5_bypass_rs", rsdata, 32'h55);
`else
        chk("t5_nobypass_ready", {31'd0, ready_int}, 32'd0);
`endif

        // Flush beats simultaneous issue and dispatch.
        for (int i = 0; i < 2; i++) begin
            disp(4'd6, 6'd0, 1, 32'd6, 6'd0, 1, 32'd6, 6'(40 + i));
            cycle();
        end
        flush = 1; issue_int = 1;
        disp(4'd7, 6'd0, 1, 32'd7, 6'd0, 1, 32'd7, 6'd50);
        cycle();
        idle();
        chk("t6_ready", {31'd0, ready_int}, 32'd0);
        chk("t6_full", {31'd0, dispatch_full}, 32'd0);

        // Randomized phase against the model.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 49) == 0);
            issue_int = ($urandom_range(0, 1) == 1);
            dispatch_en = ($urandom_range(0, 9) < 6);
            dispatch_opcode = 4'($urandom);
            dispatch_rstag = 6'($urandom_range(0, 7));
            dispatch_rsvalid = ($urandom_range(0, 1) == 1);
            dispatch_rsdata = $urandom;
            dispatch_rttag = 6'($urandom_range(0, 7));
            dispatch_rtvalid = ($urandom_range(0, 1) == 1);
            dispatch_rtdata = $urandom;
            dispatch_rdtag = 6'($urandom);
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tagout = 6'($urandom_range(0, 7));
            cdb_out = $urandom;
            cycle();
        end
        reset = 1;
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
